mem_port_arb: RTL

//  Arbitrates one shared memory bus port between the instruction-fetch requester (IF)
//  and the load/store requester (LS) of the core.

---
 rtl/mem_port_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_port_arb.sv
// Shares one memory bus port between instruction fetch (IF) and load/store (LS).
// One transaction in flight at a time, round-robin grant on contention, response steered to the owner.
module mem_port_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_vld,
   output logic                  if_req_rdy,
   input  logic [ADDR_W-1:0]     if_req_addr,
   output logic                  if_rsp_vld,
   input  logic                  if_rsp_rdy,
   output logic [DATA_W-1:0]     if_rsp_data,
   input  logic                  ls_req_vld,
   output logic                  ls_req_rdy,
   input  logic [ADDR_W-1:0]     ls_req_addr,
   input  logic                  ls_req_we,
   input  logic [DATA_W-1:0]     ls_req_wdata,
   input  logic [DATA_W/8-1:0]   ls_req_wstrb,
   output logic                  ls_rsp_vld,
   input  logic                  ls_rsp_rdy,
   output logic [DATA_W-1:0]     ls_rsp_data,
   output logic                  m_req_vld,
   input  logic                  m_req_rdy,
   output logic [ADDR_W-1:0]     m_req_addr,
   output logic                  m_req_we,
   output logic [DATA_W-1:0]     m_req_wdata,
   output logic [DATA_W/8-1:0]   m_req_wstrb,
   input  logic                  m_rsp_vld,
   output logic                  m_rsp_rdy,
   input  logic [DATA_W-1:0]     m_rsp_data,
   output logic                  busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam logic SRC_IF = 1'b0;
   localparam logic SRC_LS = 1'b1;

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   state_t              state_q, state_d;
   logic                last_gnt_q, last_gnt_d;
   logic                owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                gnt_if, gnt_ls;
   logic                owner_rsp_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         last_gnt_q <= SRC_LS;
         owner_q    <= SRC_IF;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      gnt_if     = 1'b0;
      gnt_ls     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // On contention the requester that did not win last time goes first.
            gnt_if = if_req_vld & (~ls_req_vld | (last_gnt_q == SRC_LS));
            gnt_ls = ls_req_vld & (~if_req_vld | (last_gnt_q == SRC_IF));
            if (gnt_if) begin
               addr_d     = if_req_addr;
               we_d       = 1'b0;
               wdata_d    = '0;
               wstrb_d    = '0;
               owner_d    = SRC_IF;
               last_gnt_d = SRC_IF;
               state_d    = REQ;
            end else if (gnt_ls) begin
               addr_d     = ls_req_addr;
               we_d       = ls_req_we;
               wdata_d    = ls_req_wdata;
               wstrb_d    = ls_req_wstrb;
               owner_d    = SRC_LS;
               last_gnt_d = SRC_LS;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (m_req_rdy) state_d = RSP;
         end
         RSP: begin
            if (m_rsp_vld && owner_rsp_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign owner_rsp_rdy = (owner_q == SRC_LS) ? ls_rsp_rdy : if_rsp_rdy;

   // Grants are combinational from the inputs, so mask them while reset is held.
   assign if_req_rdy  = gnt_if & ~rst;
   assign ls_req_rdy  = gnt_ls & ~rst;

   assign m_req_vld   = (state_q == REQ);
   assign m_req_addr  = addr_q;
   assign m_req_we    = we_q;
   assign m_req_wdata = wdata_q;
   assign m_req_wstrb = wstrb_q;

   assign m_rsp_rdy   = (state_q == RSP) & owner_rsp_rdy;
   assign if_rsp_vld  = (state_q == RSP) & (owner_q == SRC_IF) & m_rsp_vld;
   assign ls_rsp_vld  = (state_q == RSP) & (owner_q == SRC_LS) & m_rsp_vld;
   assign if_rsp_data = m_rsp_data;
   assign ls_rsp_data = m_rsp_data;

   assign busy        = (state_q != IDLE);

endmodule
